// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 16x-oversampled UART blocks (receiver now,
// transmitter later).
//   uart_rx_state_t : receiver frame state
//   UART_OVS        : clk cycles per bit time
//   UART_SMP_*      : ticks at which the line is sampled for the bit vote
//   UART_DATA_BITS  : character width
//   uart_maj3()     : 2-of-3 majority vote
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        UART_ST_IDLE,
        UART_ST_START,
        UART_ST_DATA,
        UART_ST_PARITY,
        UART_ST_STOP,
        UART_ST_BREAK
    } uart_rx_state_t;

    localparam int UART_OVS       = 16;
    localparam int UART_SMP_LO    = 7;
    localparam int UART_SMP_MID   = 8;
    localparam int UART_SMP_HI    = 9;
    localparam int UART_DATA_BITS = 8;

    function automatic logic uart_maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for bringing asynchronous levels into the
// clk domain. Each bit is synchronized independently (no bus coherency).
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset; both stages load RST_VAL
//   d      : asynchronous input
//   q      : synchronized output, two clk edges after d
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg[gi] <= RST_VAL[gi];
                    sync_reg[gi] <= RST_VAL[gi];
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx_16x.sv
// ---------------------------------------------------------------------------
// uart_rx_16x
// 16x-oversampling UART receiver: 1 start, 8 data (LSB first), optional
// parity, 1 stop bit. Received characters go into a one-entry holding
// register with per-character error flags and a valid/ack handshake.
//   clk            : 16x bit-rate clock
//   rst_n          : asynchronous active-low reset
//   rxd            : serial input (asynchronous, idle high)
//   rx_data        : buffered character
//   rx_valid       : rx_data and error flags are valid (level)
//   rx_ack         : consumer takes the character (honoured while rx_valid)
//   rx_parity_err  : parity mismatch on the buffered character
//   rx_frame_err   : stop bit sampled low on the buffered character
//   rx_overrun     : sticky, a character was dropped because the buffer was full
//   rx_busy        : frame reception (or break wait) in progress
// ---------------------------------------------------------------------------
module uart_rx_16x
    import uart_pkg::*;
#(
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ack,
    output logic                      rx_parity_err,
    output logic                      rx_frame_err,
    output logic                      rx_overrun,
    output logic                      rx_busy
);

    localparam int            TICK_W   = $clog2(UART_OVS);
    localparam int            IDX_W    = $clog2(UART_DATA_BITS);
    localparam [TICK_W-1:0]   TICK_LO  = TICK_W'(UART_SMP_LO);
    localparam [TICK_W-1:0]   TICK_MID = TICK_W'(UART_SMP_MID);
    localparam [TICK_W-1:0]   TICK_HI  = TICK_W'(UART_SMP_HI);
    localparam [TICK_W-1:0]   TICK_END = TICK_W'(UART_OVS - 1);
    localparam [IDX_W-1:0]    IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    // ---------------- input synchronizer (idle level 1) ----------------
    logic rxs;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rxd_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxs)
    );

    // ---------------- frame FSM state ----------------
    uart_rx_state_t              state_reg;
    logic [TICK_W-1:0]           tick_reg;
    logic [IDX_W-1:0]            bit_idx_reg;
    logic [UART_DATA_BITS-1:0]   shift_reg;
    logic                        smp_lo_reg;
    logic                        smp_mid_reg;
    logic                        par_err_pend_reg;

    // ---------------- holding register ----------------
    logic [UART_DATA_BITS-1:0]   data_reg;
    logic                        valid_reg;
    logic                        par_err_reg;
    logic                        frame_err_reg;
    logic                        overrun_reg;

    // Bit vote: the two earlier samples plus the live sample at tick 9.
    logic bit_maj;
    logic exp_parity;
    logic frame_done;
    logic load_char;
    logic drop_char;

    assign bit_maj    = uart_maj3(smp_lo_reg, smp_mid_reg, rxs);
    assign exp_parity = (^shift_reg) ^ PARITY_ODD;

    // The frame completes mid-stop-bit so the following start edge,
    // which may arrive as early as the end of the stop bit, is not missed.
    assign frame_done = (state_reg == UART_ST_STOP) && (tick_reg == TICK_HI);
    assign load_char  = frame_done && (!valid_reg || rx_ack);
    assign drop_char  = frame_done && valid_reg && !rx_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= UART_ST_IDLE;
            tick_reg         <= '0;
            bit_idx_reg      <= '0;
            shift_reg        <= '0;
            smp_lo_reg       <= 1'b1;
            smp_mid_reg      <= 1'b1;
            par_err_pend_reg <= 1'b0;
        end else begin
            if (tick_reg == TICK_LO)  smp_lo_reg  <= rxs;
            if (tick_reg == TICK_MID) smp_mid_reg <= rxs;

            case (state_reg)
                UART_ST_IDLE: begin
                    tick_reg <= '0;
                    if (!rxs) begin
                        state_reg        <= UART_ST_START;
                        bit_idx_reg      <= '0;
                        par_err_pend_reg <= 1'b0;
                    end
                end

                UART_ST_START: begin
                    tick_reg <= tick_reg + 1'b1;
                    if (tick_reg == TICK_HI && bit_maj) begin
                        // Start bit did not hold low: treat as a glitch.
                        state_reg <= UART_ST_IDLE;
                    end else if (tick_reg == TICK_END) begin
                        state_reg <= UART_ST_DATA;
                    end
                end

                UART_ST_DATA: begin
                    tick_reg <= tick_reg + 1'b1;
                    if (tick_reg == TICK_HI) begin
                        shift_reg <= {bit_maj, shift_reg[UART_DATA_BITS-1:1]};
                    end
                    if (tick_reg == TICK_END) begin
                        if (bit_idx_reg == IDX_LAST) begin
                            state_reg <= PARITY_EN ? UART_ST_PARITY : UART_ST_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end
                end

                UART_ST_PARITY: begin
                    tick_reg <= tick_reg + 1'b1;
                    if (tick_reg == TICK_HI && bit_maj != exp_parity) begin
                        par_err_pend_reg <= 1'b1;
                    end
                    if (tick_reg == TICK_END) begin
                        state_reg <= UART_ST_STOP;
                    end
                end

                UART_ST_STOP: begin
                    tick_reg <= tick_reg + 1'b1;
                    if (tick_reg == TICK_HI) begin
                        tick_reg  <= '0;
                        // A low stop bit may be the start of a line break;
                        // hold off start detection until the line goes high.
                        state_reg <= bit_maj ? UART_ST_IDLE : UART_ST_BREAK;
                    end
                end

                UART_ST_BREAK: begin
                    tick_reg <= '0;
                    if (rxs) state_reg <= UART_ST_IDLE;
                end

                default: begin
                    tick_reg  <= '0;
                    state_reg <= UART_ST_IDLE;
                end
            endcase
        end
    end

    // Holding register and handshake. A load takes priority over an ack
    // that lands in the same cycle (the ack consumes the old character).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            par_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (load_char) begin
                data_reg      <= shift_reg;
                valid_reg     <= 1'b1;
                par_err_reg   <= par_err_pend_reg;
                frame_err_reg <= !bit_maj;
            end else if (valid_reg && rx_ack) begin
                valid_reg     <= 1'b0;
                par_err_reg   <= 1'b0;
                frame_err_reg <= 1'b0;
            end

            if (drop_char) begin
                overrun_reg <= 1'b1;
            end else if (valid_reg && rx_ack) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign rx_data       = data_reg;
    assign rx_valid      = valid_reg;
    assign rx_parity_err = par_err_reg;
    assign rx_frame_err  = frame_err_reg;
    assign rx_overrun    = overrun_reg;
    assign rx_busy       = (state_reg != UART_ST_IDLE);

endmodule

// File: tb/tb_uart_rx_16x.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_16x
// Drives serial frames onto rxd (16 clk per bit, changes on the falling
// clock edge) and compares the receiver outputs against a character-level
// model of the holding buffer: each frame either lands in the buffer or,
// if the buffer is full and not acked, sets the overrun flag.
// ---------------------------------------------------------------------------
module tb_uart_rx_16x;

    localparam bit TB_PAR_EN  = 1'b1;
    localparam bit TB_PAR_ODD = 1'b0;
    localparam int BIT_CLKS   = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    always #5 clk = ~clk;

    uart_rx_16x #(
        .PARITY_EN  (TB_PAR_EN),
        .PARITY_ODD (TB_PAR_ODD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ack        (rx_ack),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .rx_busy       (rx_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Character-level model of the holding buffer
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_perr;
    logic       m_ferr;
    logic       m_ovr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic good_parity(input logic [7:0] d);
        return (^d) ^ TB_PAR_ODD;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // One completed frame. ack_same: consumer acks on the completion cycle.
    task automatic model_frame(input logic [7:0] d, input logic p, input logic s,
                               input bit ack_same);
        if (!m_valid || ack_same) begin
            if (ack_same && m_valid) m_ovr = 1'b0;
            m_valid = 1'b1;
            m_data  = d;
            m_perr  = TB_PAR_EN && (p != good_parity(d));
            m_ferr  = !s;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, ".valid"}, 32'(rx_valid),      32'(m_valid));
        chk({pfx, ".data"},  32'(rx_data),       32'(m_data));
        chk({pfx, ".perr"},  32'(rx_parity_err), 32'(m_perr));
        chk({pfx, ".ferr"},  32'(rx_frame_err),  32'(m_ferr));
        chk({pfx, ".ovr"},   32'(rx_overrun),    32'(m_ovr));
        chk({pfx, ".busy"},  32'(rx_busy),       32'(0));
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, ".valid"}, 32'(rx_valid),      32'(0));
        chk({pfx, ".data"},  32'(rx_data),       32'(0));
        chk({pfx, ".perr"},  32'(rx_parity_err), 32'(0));
        chk({pfx, ".ferr"},  32'(rx_frame_err),  32'(0));
        chk({pfx, ".ovr"},   32'(rx_overrun),    32'(0));
        chk({pfx, ".busy"},  32'(rx_busy),       32'(0));
    endtask

    // Called at a negedge; returns at the negedge after the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (TB_PAR_EN) begin
            rxd = p;
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = s;
        repeat (BIT_CLKS) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_perr  = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;
        int         gap;

        rst_n  = 1'b0;
        rxd    = 1'b1;
        rx_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Clean byte with exact latency: rxd falls before P1, rxs low after P2,
        // E = P3, so rx_valid must rise on P173.
        fork
            send_frame(8'h52, 1'b1, 1'b1);
            begin
                repeat (172) @(posedge clk);
                @(negedge clk);
                chk("lat_before", 32'(rx_valid), 32'(0));
                @(posedge clk);
                @(negedge clk);
                chk("lat_edge", 32'(rx_valid), 32'(1));
            end
        join
        model_frame(8'h52, 1'b1, 1'b1, 0);
        $display("frame data=52 clean");
        check_all("clean");
        ack_pulse();
        check_all("clean_ack");

        // Parity error
        send_frame(8'h72, 1'b1, 1'b1);
        model_frame(8'h72, 1'b1, 1'b1, 0);
        $display("frame data=72 bad parity");
        check_all("parity");
        chk("parity_flag", 32'(rx_parity_err), 32'(1));
        ack_pulse();

        // Framing error followed by a long break
        send_frame(8'h55, 1'b0, 1'b0);
        rxd = 1'b0;
        model_frame(8'h55, 1'b0, 1'b0, 0);
        repeat (20 * BIT_CLKS) @(negedge clk);
        chk("brk_busy_mid", 32'(rx_busy), 32'(1));
        chk("brk_ferr", 32'(rx_frame_err), 32'(1));
        repeat (20 * BIT_CLKS) @(negedge clk);
        chk("brk_busy_end", 32'(rx_busy), 32'(1));
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        $display("frame data=55 framing error + break");
        check_all("brk_release");
        ack_pulse();
        check_all("brk_ack");

        // Glitch: 5 clk low. START at P3, vote at tick 9 on P13 returns to IDLE.
        fork
            begin
                rxd = 1'b0;
                repeat (5) @(negedge clk);
                rxd = 1'b1;
            end
            begin
                repeat (12) @(posedge clk);
                @(negedge clk);
                chk("glitch_busy", 32'(rx_busy), 32'(1));
                @(posedge clk);
                @(negedge clk);
                chk("glitch_idle", 32'(rx_busy), 32'(0));
            end
        join
        repeat (20) @(negedge clk);
        $display("glitch 5 clk");
        check_all("glitch");

        // Overrun: two back-to-back frames, no ack
        send_frame(8'h11, good_parity(8'h11), 1'b1);
        model_frame(8'h11, good_parity(8'h11), 1'b1, 0);
        send_frame(8'h22, good_parity(8'h22), 1'b1);
        model_frame(8'h22, good_parity(8'h22), 1'b1, 0);
        $display("frames 11,22 no ack");
        check_all("ovr");
        ack_pulse();
        check_all("ovr_ack");

        // Repeat with the ack landing exactly on the completion edge of 0x22
        send_frame(8'h11, good_parity(8'h11), 1'b1);
        model_frame(8'h11, good_parity(8'h11), 1'b1, 0);
        fork
            send_frame(8'h22, good_parity(8'h22), 1'b1);
            begin
                repeat (172) @(posedge clk);
                @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        model_frame(8'h22, good_parity(8'h22), 1'b1, 1);
        $display("frames 11,22 ack on completion");
        check_all("ack_same");

        // Reset during data bit 4 of 0xA5 (buffer still holds 0x22)
        d   = 8'hA5;
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = d[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst_n = 1'b0;
        rxd   = 1'b1;
        model_reset();
        @(negedge clk);
        check_zero("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20 * BIT_CLKS) @(negedge clk);
        check_all("midrst_after");
        send_frame(8'h3C, good_parity(8'h3C), 1'b1);
        model_frame(8'h3C, good_parity(8'h3C), 1'b1, 0);
        $display("frame data=3c after reset");
        check_all("post_rst");
        ack_pulse();

        // Randomized frames with random errors, gaps and ack decisions
        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom_range(0, 255));
            p   = good_parity(d) ^ ($urandom_range(0, 4) == 0);
            s   = !($urandom_range(0, 7) == 0);
            send_frame(d, p, s);
            model_frame(d, p, s, 0);
            gap = s ? $urandom_range(0, 8) : $urandom_range(4, 8);
            repeat (gap) @(negedge clk);
            $display("rnd %0d data=%02h par=%0d stop=%0d gap=%0d", k, d, p, s, gap);
            check_all("rnd");
            if ($urandom_range(0, 9) < 6) begin
                ack_pulse();
                check_all("rnd_ack");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_16x.md
# uart_rx_16x

Oversampling UART receiver for the FPGA side of the serial link. It samples the `rxd` pin on a clock running at 16× the bit rate and recovers 8-bit characters with an optional parity bit and one stop bit. Each character is held in a one-entry buffer with per-character error flags. It sits directly upstream of `uart_if`'s character-handling logic and feeds it received bytes through a valid/ack handshake.

## Interface
Parameters:
- `PARITY_EN`, default 1: 1 means a parity bit follows the data bits.
- `PARITY_ODD`, default 0: 0 means even parity, 1 means odd parity. Ignored when `PARITY_EN`=0.

Ports (clock and reset first):
- `clk`  in  1: 16× bit-rate clock. One bit time is 16 `clk` cycles.
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `rxd`  in  1: serial input pin. Asynchronous to `clk`; idle level is 1.
- `rx_data`  out  8: received character, LSB first on the line.
- `rx_valid`  out  1: level signal; `rx_data` and the error flags are valid.
- `rx_ack`  in  1: consumer takes the buffered character. Sampled only while `rx_valid`=1.
- `rx_parity_err`  out  1: parity mismatch on the buffered character.
- `rx_frame_err`  out  1: stop bit sampled as 0 on the buffered character.
- `rx_overrun`  out  1: sticky flag; at least one character was dropped.
- `rx_busy`  out  1: frame reception in progress (state is not IDLE).

## Operation
- **Input synchronizer:** `rxd` passes through 2 flops; both reset to 1. All logic uses the synchronized value `rxs`.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK.
- **Bit counter:** `tick` runs 0..15 within each bit.
  - `rxs` is sampled at ticks 7, 8 and 9.
  - The bit value is the 2-of-3 majority, decided at tick 9.
  - Tick 15 ends the bit.
- **IDLE:** when `rxs`=0, go to START with `tick`=0.
- **START:** at tick 9, if the majority is 1 (glitch), return to IDLE and load nothing. Otherwise continue; at tick 15 go to DATA.
- **DATA:** 8 bits, shifted LSB first; a bit index counts 0..7. After bit 7, tick 15, go to PARITY when `PARITY_EN`=1, otherwise STOP.
- **PARITY:** compute the expected bit as the XOR of the data bits, XOR `PARITY_ODD`. A mismatch sets a pending parity error.
- **STOP:** the frame completes at tick 9, not tick 15. This lets a back-to-back start edge be caught.
  - Stop majority 1: go to IDLE.
  - Stop majority 0: set pending frame error, then go to BREAK.
- **BREAK:** wait until `rxs`=1, then go to IDLE. No start detection happens in BREAK.
- **Load at frame completion:**
  - If `rx_valid`=0, or `rx_ack`=1 in the same cycle: load `rx_data`, `rx_parity_err` and `rx_frame_err`, and set `rx_valid`=1. A framing-error byte is still delivered.
  - Otherwise the new character is discarded, the old one is kept, and `rx_overrun` is set.
- **Handshake:**
  - `rx_ack`=1 while `rx_valid`=1 with no simultaneous load: clear `rx_valid` and both error flags on the next edge.
  - `rx_ack` also clears `rx_overrun`, unless an overrun is set in that same cycle; set wins.
  - `rx_ack` while `rx_valid`=0 is ignored.

## Timing
- **Reset values:** while `rst_n`=0, all outputs are 0, the state is IDLE, and the synchronizer flops are 1. Reset mid-frame aborts the frame; the partial character is never delivered.
- **Latency:** let edge E be the first rising edge at which `rxs`=0 in IDLE.
  - `rx_valid` rises on edge E+170 with `PARITY_EN`=1: 10 bits × 16 + 9 + 1.
  - `rx_valid` rises on edge E+154 with `PARITY_EN`=0.
- **Pin to `rxs`:** 2 `clk` edges.
- **Back-to-back frames:** the next start edge is detectable from the cycle after frame completion.
- **Tolerance:** accepted bit-rate mismatch is at least ±3%.
- `rx_busy` is 1 from edge E through the completion edge, and also throughout BREAK.

## Structure
- **Shared package `uart_pkg`** holds:
  - the state enum `uart_rx_state_t`;
  - `UART_OVS` = 16;
  - `UART_SMP_LO` = 7, `UART_SMP_MID` = 8, `UART_SMP_HI` = 9;
  - `UART_DATA_BITS` = 8.
  These are shared with the future `uart_tx_16x`.
- **Sub-module `sync_2ff`:** a generic 2-flop synchronizer with reset value as a parameter. It is instantiated once here.
- Everything else stays in this module: FSM, tick/bit counters, shift register, holding register.

## Test plan
- **Clean byte:** send 0x52 ('R') with even parity bit 1 and stop 1 at 16 clk/bit. `rx_data`=0x52 with `rx_valid` at E+170 and no error flags. `rx_ack` pulse → `rx_valid`=0 on the next edge.
- **Parity error:** send 0x72 ('r') with parity bit forced to 1 (correct is 0). `rx_data`=0x72, `rx_parity_err`=1, `rx_frame_err`=0.
- **Framing error and break:** send 0x55 with stop=0, then hold `rxd`=0 for 40 bit times, then 1. Result: `rx_frame_err`=1, `rx_busy`=1 until `rxd` returns high, and no second character.
- **Glitch rejection:** drive `rxd` low for 5 clk in IDLE. No state beyond START, `rx_valid` stays 0, and IDLE is re-entered at tick 9.
- **Overrun:** send 0x11 then 0x22 back-to-back with no ack. `rx_data`=0x11 and `rx_overrun`=1. Ack → `rx_overrun`=0. A repeat with ack on the exact completion cycle of 0x22 → `rx_data`=0x22, `rx_valid` stays 1, no overrun.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 4 of 0xA5, release, then send 0x3C. Outputs are 0 during reset and only 0x3C is delivered.
